// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction prefetch queue: fetches ahead into a circular buffer, flushed on redirect
module ifetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_f,
  input  logic                     fetch_en,
  output logic [15:0]              im_addr,
  input  logic [31:0]              im_data,
  input  logic                     redirect,
  input  logic [15:0]              redirect_addr,
  input  logic                     deq,
  output logic [31:0]              instr_out,
  output logic [15:0]              instr_pc,
  output logic                     instr_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [31:0]   instr_mem [DEPTH];
  logic [15:0]   pc_mem    [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [15:0]   fetch_pc;
  logic          pop;
  logic          push;

  assign instr_valid = (count != '0);
  assign pop         = deq & instr_valid & ~redirect;
  // A full queue still accepts a fetch when the head leaves in the same cycle.
  assign push        = fetch_en & ~redirect & ((count != FULL) | pop);

  assign im_addr   = fetch_pc;
  assign instr_out = instr_valid ? instr_mem[rd_ptr] : 32'h0;
  assign instr_pc  = instr_valid ? pc_mem[rd_ptr]    : 16'h0;

  always_ff @(posedge clk) begin
    if (rst_f) begin
      fetch_pc <= 16'h0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_addr;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + AW'(1);
        fetch_pc <= fetch_pc + 16'h1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: count gates everything read out of it.
  always_ff @(posedge clk) begin
    if (push && !rst_f) begin
      instr_mem[wr_ptr] <= im_data;
      pc_mem[wr_ptr]    <= fetch_pc;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - directed and randomized checks of ifetch_queue against a queue-based model
module tb_ifetch_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_f;
  logic        fetch_en;
  logic [15:0] im_addr;
  logic [31:0] im_data;
  logic        redirect;
  logic [15:0] redirect_addr;
  logic        deq;
  logic [31:0] instr_out;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic [2:0]  count;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 0;

  typedef struct {
    logic [31:0] instr;
    logic [15:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] m_pc;

  ifetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_f(rst_f), .fetch_en(fetch_en), .im_addr(im_addr),
    .im_data(im_data), .redirect(redirect), .redirect_addr(redirect_addr),
    .deq(deq), .instr_out(instr_out), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .count(count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return 32'hA000_0000 + {16'h0, a};
  endfunction

  always_comb im_data = mem_word(im_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: a plain FIFO of fetched words plus the next fetch address.
  always @(posedge clk) begin
    bit   do_pop;
    bit   do_push;
    ent_t e;
    if (rst_f) begin
      mq.delete();
      m_pc = 16'h0;
    end else if (redirect) begin
      mq.delete();
      m_pc = redirect_addr;
    end else begin
      do_pop  = deq && (mq.size() > 0);
      do_push = fetch_en && ((mq.size() < DEPTH) || do_pop);
      e.instr = mem_word(m_pc);
      e.pc    = m_pc;
      if (do_pop)  void'(mq.pop_front());
      if (do_push) begin
        mq.push_back(e);
        m_pc = m_pc + 16'h1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_count", {29'h0, count}, mq.size());
      check("model_valid", {31'h0, instr_valid}, (mq.size() > 0) ? 1 : 0);
      check("model_instr", instr_out, (mq.size() > 0) ? mq[0].instr : 32'h0);
      check("model_pc", {16'h0, instr_pc}, (mq.size() > 0) ? {16'h0, mq[0].pc} : 32'h0);
      check("model_im_addr", {16'h0, im_addr}, {16'h0, m_pc});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] wrap_seq [4];
    wrap_seq[0] = 16'hFFFE;
    wrap_seq[1] = 16'hFFFF;
    wrap_seq[2] = 16'h0000;
    wrap_seq[3] = 16'h0001;

    rst_f = 1; fetch_en = 0; deq = 0; redirect = 0; redirect_addr = 16'h0;
    cyc();
    chk_en = 1;
    check("reset_count", {29'h0, count}, 0);
    check("reset_valid", {31'h0, instr_valid}, 0);
    check("reset_instr", instr_out, 32'h0);
    check("reset_pc", {16'h0, instr_pc}, 0);
    check("reset_im_addr", {16'h0, im_addr}, 0);

    // Fill
    rst_f = 0; fetch_en = 1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check("fill_count", {29'h0, count}, i);
      if (i == 1) check("first_valid", {31'h0, instr_valid}, 1);
    end
    cyc();
    check("fill_hold", {29'h0, count}, 4);
    check("fill_im_addr", {16'h0, im_addr}, 32'h4);
    check("fill_instr", instr_out, 32'hA000_0000);
    check("fill_pc", {16'h0, instr_pc}, 0);

    // Stream from a full queue
    deq = 1;
    for (int k = 0; k < 6; k++) begin
      check("stream_pc", {16'h0, instr_pc}, k);
      cyc();
      check("stream_count", {29'h0, count}, 4);
      check("stream_im_addr", {16'h0, im_addr}, 5 + k);
    end

    // Reload to pcs 5..8, then redirect with a simultaneous deq
    deq = 0; redirect = 1; redirect_addr = 16'h0005;
    cyc();
    redirect = 0;
    for (int i = 0; i < 5; i++) cyc();
    check("redir_pre_count", {29'h0, count}, 4);
    check("redir_pre_pc", {16'h0, instr_pc}, 5);
    redirect = 1; redirect_addr = 16'h0040; deq = 1;
    cyc();
    check("redir_count", {29'h0, count}, 0);
    check("redir_valid", {31'h0, instr_valid}, 0);
    check("redir_im_addr", {16'h0, im_addr}, 32'h40);
    redirect = 0; deq = 0;
    cyc();
    check("redir_pc", {16'h0, instr_pc}, 32'h40);
    check("redir_count1", {29'h0, count}, 1);

    // Address wrap
    redirect = 1; redirect_addr = 16'hFFFE; deq = 1;
    cyc();
    redirect = 0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("wrap_pc", {16'h0, instr_pc}, {16'h0, wrap_seq[k]});
    end

    // Halted fetch draining to empty, then deq on empty
    fetch_en = 0;
    cyc();
    cyc();
    check("halt_count", {29'h0, count}, 0);
    check("halt_im_addr", {16'h0, im_addr}, 32'h2);
    check("halt_instr", instr_out, 32'h0);
    check("halt_valid", {31'h0, instr_valid}, 0);

    // Reset mid-run overrides redirect and deq
    fetch_en = 1; deq = 0;
    for (int i = 0; i < 3; i++) cyc();
    check("mid_pre_count", {29'h0, count}, 3);
    rst_f = 1; redirect = 1; redirect_addr = 16'h1234; deq = 1;
    cyc();
    check("mid_count", {29'h0, count}, 0);
    check("mid_im_addr", {16'h0, im_addr}, 0);
    check("mid_valid", {31'h0, instr_valid}, 0);
    rst_f = 0; redirect = 0; deq = 0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_f    = ($urandom_range(0, 99) == 0);
      redirect = ($urandom_range(0, 15) == 0);
      fetch_en = ($urandom_range(0, 3) != 0);
      deq      = ($urandom_range(0, 1) == 1);
      redirect_addr = ($urandom_range(0, 3) == 0) ? (16'hFFFC + 16'($urandom_range(0, 3)))
                                                  : 16'($urandom);
      cyc();
    end

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter: DEPTH, 4, number of prefetch entries (power of two, 2..16).
REQ-002 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_f  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: fetch_en  input  1  permits new fetches when high (low = halt fetching).
REQ-005 SHALL have port: im_addr  output  16  word address driven to instruction memory (equals fetch_pc).
REQ-006 SHALL have port: im_data  input  32  instruction memory read data, combinational from im_addr in the same cycle.
REQ-007 SHALL have port: redirect  input  1  branch/jump taken; flush queue and reload fetch_pc.
REQ-008 SHALL have port: redirect_addr  input  16  new fetch address used when redirect is high.
REQ-009 SHALL have port: deq  input  1  consumer (IR load) takes the head entry this cycle.
REQ-010 SHALL have port: instr_out  output  32  head-entry instruction.
REQ-011 SHALL have port: instr_pc  output  16  address the head instruction was fetched from.
REQ-012 SHALL have port: instr_valid  output  1  head entry present (count > 0).
REQ-013 SHALL have port: count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-014 SHALL hold internal state: fetch_pc (16b), circular buffer of DEPTH entries {instr 32b, pc 16b}, write pointer, read pointer, count.
REQ-015 SHALL compute pop = deq AND instr_valid AND NOT redirect; deq while empty SHALL be ignored with no state change.
REQ-016 SHALL compute push = fetch_en AND NOT redirect AND (count < DEPTH OR pop).
REQ-017 SHALL, on push, write {im_data, fetch_pc} at write pointer, advance write pointer modulo DEPTH, and set fetch_pc <= fetch_pc + 1 (16-bit, 16'hFFFF wraps to 16'h0000).
REQ-018 SHALL, on pop, advance read pointer modulo DEPTH.
REQ-019 SHALL update count as: push only +1; pop only -1; push and pop together unchanged; neither unchanged.
REQ-020 SHALL, when full (count == DEPTH) and deq high, push and pop in the same cycle (count stays DEPTH).
REQ-021 SHALL, when redirect is high, set count <= 0, read and write pointers <= 0, fetch_pc <= redirect_addr; no push, no pop that cycle; redirect overrides deq and fetch_en.
REQ-022 SHALL first fetch from redirect_addr in the cycle after redirect; instr_valid SHALL be low in that cycle and high in the next (2-cycle redirect-to-valid latency when fetch_en high).
REQ-023 SHALL drive instr_out/instr_pc from the head entry combinationally from registered state; when instr_valid is low, instr_out SHALL be 32'h0 and instr_pc 16'h0.
REQ-024 SHALL drive im_addr = fetch_pc continuously, independent of fetch_en.
REQ-025 SHALL keep fetch_pc unchanged in any cycle without push or redirect.

Reset
REQ-026 SHALL, on rising clk with rst_f high, set fetch_pc 16'h0000, pointers 0, count 0; outputs then read instr_valid 0, instr_out 32'h0, instr_pc 16'h0, im_addr 16'h0.
REQ-027 SHALL give rst_f priority over redirect, deq and fetch_en; reset mid-operation discards all queued entries.
REQ-028 SHALL, with fetch_en high, present address 0's instruction with instr_valid high in the first cycle after the first post-reset edge.

Verification
REQ-029 Fill: reset, fetch_en=1, deq=0, im returns 32'hA000_0000+addr -> count 1,2,3,4 then holds 4; im_addr stops at 16'h0004; head instr_out 32'hA000_0000, instr_pc 0.
REQ-030 Stream: full queue, deq=1 for 6 cycles -> count stays 4; instr_pc sequence 0,1,2,3,4,5; im_addr advances 4..10.
REQ-031 Redirect: queue holding pcs 5..8, redirect=1 with redirect_addr=16'h0040 and deq=1 same cycle -> next cycle count 0, instr_valid 0, im_addr 16'h0040; following cycle instr_pc 16'h0040, count 1.
REQ-032 Wrap: redirect_addr=16'hFFFE, fetch_en=1, deq=1 -> instr_pc sequence FFFE, FFFF, 0000, 0001.
REQ-033 Empty/halt: fetch_en=0, deq=1 on empty queue -> count 0, pointers and fetch_pc unchanged, instr_out 32'h0.
REQ-034 Reset mid-run: count 3, rst_f=1 with redirect=1 and deq=1 -> count 0, im_addr 16'h0000, instr_valid 0.
